updown_counter_mod: RTL and testbench

Parametrised loadable up/down counter with a programmable modulus, count enable, and selectable wrap or saturate behaviour. It is the next generation of the team's fixed 4-bit loadable up/down counter. It is generalised in width and adds a runtime upper limit, terminal-count flags and a wrap pulse. It serves as a general-purpose timer or event counter in datapath and control blocks.

---
 rtl/updown_counter_mod.sv | 73 +++++++
 tb/tb_updown_counter_mod.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/updown_counter_mod.sv
// Loadable up/down counter with a runtime upper limit, wrap/saturate mode,
// terminal-count flag and a registered wrap pulse.
module updown_counter_mod #(
  parameter int unsigned     WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             mod,
  input  logic             sat,
  input  logic [WIDTH-1:0] max,
  output logic [WIDTH-1:0] q,
  output logic             wrap,
  output logic             at_lim
);

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  logic [WIDTH-1:0] q_d, q_q;
  logic             wrap_d, wrap_q;

  // Every comparison happens before any arithmetic, so no step can overflow.
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (load) begin
      q_d = (d > max) ? max : d;
    end else if (en) begin
      if (mod) begin
        if (q_q >= max) begin
          if (sat) begin
            q_d = max;
          end else begin
            q_d    = '0;
            wrap_d = 1'b1;
          end
        end else begin
          q_d = q_q + One;
        end
      end else begin
        // A count stranded above a lowered limit snaps back to the limit.
        if (q_q > max) begin
          q_d = max;
        end else if (q_q != '0) begin
          q_d = q_q - One;
        end else if (!sat) begin
          q_d    = max;
          wrap_d = 1'b1;
        end else begin
          q_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q    <= RST_VAL;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign q      = q_q;
  assign wrap   = wrap_q;
  assign at_lim = mod ? (q_q >= max) : (q_q == '0);

endmodule

// File: tb/tb_updown_counter_mod.sv
// Directed bench for updown_counter_mod at WIDTH=4, RST_VAL=0.
module tb_updown_counter_mod;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       load;
  logic [3:0] d;
  logic       mod;
  logic       sat;
  logic [3:0] max;
  logic [3:0] q;
  logic       wrap;
  logic       at_lim;

  int n_chk = 0;
  int n_bad = 0;

  updown_counter_mod #(
    .WIDTH  (4),
    .RST_VAL(4'd0)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .load  (load),
    .d     (d),
    .mod   (mod),
    .sat   (sat),
    .max   (max),
    .q     (q),
    .wrap  (wrap),
    .at_lim(at_lim)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge, away from the sampling edge.
  task automatic drive(input logic l, input logic [3:0] dv, input logic e, input logic m,
                       input logic s, input logic [3:0] mx);
    @(negedge clk);
    load = l;
    d    = dv;
    en   = e;
    mod  = m;
    sat  = s;
    max  = mx;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst  = 1'b0;
    en   = 1'b0;
    load = 1'b0;
    d    = 4'd0;
    mod  = 1'b0;
    sat  = 1'b0;
    max  = 4'd9;
    #3;
    chk("rst_q", q, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_atlim", at_lim, 1);
    @(negedge clk);
    rst = 1'b1;

    // Load wins over en
    drive(1, 3, 1, 1, 0, 9); step(); chk("load3", q, 3);
    drive(1, 7, 1, 1, 0, 9); step(); chk("load7", q, 7);

    // Up wrap at max=9
    drive(0, 0, 1, 1, 0, 9);
    step(); chk("up8", q, 8); chk("up8_atlim", at_lim, 0);
    step(); chk("up9", q, 9); chk("up9_atlim", at_lim, 1); chk("up9_wrap", wrap, 0);
    step(); chk("up0", q, 0); chk("up0_wrap", wrap, 1);
    step(); chk("up1", q, 1); chk("up1_wrap", wrap, 0);

    // Down wrap
    drive(0, 0, 1, 0, 0, 9);
    step(); chk("dn0", q, 0); chk("dn0_wrap", wrap, 0); chk("dn0_atlim", at_lim, 1);
    step(); chk("dn9", q, 9); chk("dn9_wrap", wrap, 1);

    // Down saturate
    drive(1, 1, 0, 0, 1, 9); step(); chk("load1", q, 1);
    drive(0, 0, 1, 0, 1, 9);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("dsat_q", q, 0);
      chk("dsat_wrap", wrap, 0);
      chk("dsat_atlim", at_lim, 1);
    end

    // Load clamp and max shrink
    drive(1, 14, 0, 0, 0, 9); step(); chk("clamp", q, 9);
    drive(0, 0, 1, 0, 0, 5);
    step(); chk("shrink5", q, 5);
    step(); chk("shrink4", q, 4);
    drive(1, 9, 0, 1, 0, 9); step(); chk("load9", q, 9);
    drive(0, 0, 1, 1, 0, 5);
    #1; chk("over_atlim", at_lim, 1);
    step(); chk("over_q", q, 0); chk("over_wrap", wrap, 1);

    // max=0
    drive(0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      step(); chk("m0up_q", q, 0); chk("m0up_wrap", wrap, 1);
    end
    drive(0, 0, 1, 0, 0, 0); step(); chk("m0dn_q", q, 0); chk("m0dn_wrap", wrap, 1);
    drive(0, 0, 1, 1, 1, 0); step(); chk("m0sat_q", q, 0); chk("m0sat_wrap", wrap, 0);

    // Full range
    drive(1, 15, 0, 1, 0, 15); step(); chk("full15", q, 15); chk("full_atlim", at_lim, 1);
    drive(0, 0, 1, 1, 0, 15); step(); chk("full0", q, 0); chk("full_wrap", wrap, 1);

    // Hold
    drive(1, 5, 0, 1, 0, 15); step(); chk("load5", q, 5);
    drive(0, 0, 0, 1, 0, 15); step(); chk("hold_q", q, 5); chk("hold_wrap", wrap, 0);

    // Priority and async reset
    drive(1, 6, 1, 1, 0, 9); step(); chk("prio", q, 6);
    drive(1, 8, 0, 1, 0, 9); step(); chk("load8", q, 8);
    drive(0, 0, 1, 1, 0, 9);
    step(); chk("pre9", q, 9);
    step(); chk("pre_wrap", wrap, 1);
    #1; rst = 1'b0;
    #1; chk("arst_wrap", wrap, 0); chk("arst_q0", q, 0);
    step(); chk("arst_hold", q, 0);
    @(negedge clk); rst = 1'b1;
    step(); chk("resume1", q, 1);
    step(); chk("resume2", q, 2);
    #1; rst = 1'b0;
    #1; chk("arst_q", q, 0); chk("arst_wrap2", wrap, 0);
    @(negedge clk); rst = 1'b1;
    step(); chk("resume_b", q, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
